// File: rtl/noekeon_round_ctrl.sv
// noekeon_round_ctrl: sequences key preparation, the NR rounds and the final transform of the Noekeon datapath,
// generating forward (encrypt) or backward (decrypt) round constants.
module noekeon_round_ctrl #(
  parameter int         NR      = 16,
  parameter logic [7:0] RC_INIT = 8'h80,
  parameter logic [7:0] RC_POLY = 8'h1B
) (
  input  logic       inClk,
  input  logic       inReset,
  input  logic       inStart,
  input  logic       inDecrypt,
  input  logic       inAbort,
  output logic       outBusy,
  output logic       outDone,
  output logic       outWrKey,
  output logic       outKeyPrep,
  output logic       outWrInt,
  output logic       outFinal,
  output logic [7:0] outRcIn,
  output logic [7:0] outRcOut,
  output logic [4:0] outRound
);
  typedef enum logic [2:0] {IDLE, KEYLD, KEYPREP, ROUND, FINAL, DONE} state_t;
  function automatic logic [7:0] rc_fwd(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RC_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] rc_bwd(input logic [7:0] r);
    return r[0] ? (((r ^ RC_POLY) >> 1) | 8'h80) : (r >> 1);
  endfunction
  function automatic logic [7:0] rc_at(input int n);
    logic [7:0] r;
    r = RC_INIT;
    for (int i = 0; i < n; i++) r = rc_fwd(r);
    return r;
  endfunction
  // decryption walks the constant chain backwards from Rc[NR]
  localparam logic [7:0] RC_LAST = rc_at(NR);
  state_t     state, state_nx;
  logic [7:0] rc, rc_nx;
  logic [4:0] round, round_nx;
  logic       mode, mode_nx;
  logic       active;
  always_ff @(posedge inClk) begin
    if (!inReset) begin
      state <= IDLE;
      rc    <= RC_INIT;
      round <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      rc    <= rc_nx;
      round <= round_nx;
      mode  <= mode_nx;
    end
  end
  always_comb begin
    state_nx = state;
    rc_nx    = rc;
    round_nx = round;
    mode_nx  = mode;
    case (state)
      IDLE: if (inStart) begin
        mode_nx  = inDecrypt;
        rc_nx    = inDecrypt ? RC_LAST : RC_INIT;
        state_nx = inDecrypt ? KEYLD : ROUND;
      end
      KEYLD:   state_nx = KEYPREP;
      KEYPREP: state_nx = ROUND;
      ROUND: begin
        rc_nx    = mode ? rc_bwd(rc) : rc_fwd(rc);
        round_nx = round + 5'd1;
        state_nx = (round == 5'(NR - 1)) ? FINAL : ROUND;
      end
      FINAL: state_nx = DONE;
      DONE: begin
        state_nx = IDLE;
        round_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
    if (inAbort && state != IDLE) begin
      state_nx = IDLE;
      round_nx = '0;
      rc_nx    = RC_INIT;
    end
  end
  assign active     = (state == ROUND) || (state == FINAL);
  assign outBusy    = state != IDLE;
  assign outDone    = state == DONE;
  assign outWrKey   = state == KEYLD;
  assign outKeyPrep = state == KEYPREP;
  assign outWrInt   = active;
  assign outFinal   = state == FINAL;
  assign outRcIn    = (active && !mode) ? rc : 8'h00;
  assign outRcOut   = (active && mode) ? rc : 8'h00;
  assign outRound   = active ? round : 5'd0;
endmodule

// File: tb/tb_noekeon_round_ctrl.sv
// tb_noekeon_round_ctrl: directed checks of the Noekeon round controller against hand-computed
// strobe, round and constant sequences.
module tb_noekeon_round_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, decrypt = 1'b0, abort = 1'b0;
  logic       busy, done, wr_key, key_prep, wr_int, final_t;
  logic [7:0] rc_in, rc_out;
  logic [4:0] round;
  logic [26:0] obs;
  int checks = 0, errors = 0;
  logic [7:0] enc_rc [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                                8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};
  noekeon_round_ctrl dut (
    .inClk(clk), .inReset(rst_n), .inStart(start), .inDecrypt(decrypt), .inAbort(abort),
    .outBusy(busy), .outDone(done), .outWrKey(wr_key), .outKeyPrep(key_prep), .outWrInt(wr_int),
    .outFinal(final_t), .outRcIn(rc_in), .outRcOut(rc_out), .outRound(round)
  );
  always #5 clk = ~clk;
  assign obs = {busy, done, wr_key, key_prep, wr_int, final_t, rc_in, rc_out, round};
  function automatic logic [26:0] vec(input logic b, d, k, p, w, f, input logic [7:0] ri, ro,
                                      input logic [4:0] r);
    return {b, d, k, p, w, f, ri, ro, r};
  endfunction
  // expected outputs n cycles after the accepting edge; 0 once the block is back in IDLE
  function automatic logic [26:0] exp_at(input logic dec, input int n);
    int m;
    logic [7:0] c;
    m = dec ? n - 2 : n;
    if (dec && n == 1) return vec(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 5'd0);
    if (dec && n == 2) return vec(1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 5'd0);
    if (m >= 1 && m <= 16) begin
      c = dec ? enc_rc[17 - m] : enc_rc[m - 1];
      return vec(1, 0, 0, 0, 1, 0, dec ? 8'h00 : c, dec ? c : 8'h00, 5'(m - 1));
    end
    if (m == 17) begin
      c = dec ? enc_rc[0] : enc_rc[16];
      return vec(1, 0, 0, 0, 1, 1, dec ? 8'h00 : c, dec ? c : 8'h00, 5'd16);
    end
    if (m == 18) return vec(1, 1, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0);
    return '0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int n, input logic [26:0] o, e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, o, e);
    end
  endtask
  // accept a start, then check cycles 1..last; optional start poke, abort or reset at given cycles
  task automatic op(input string tag, input logic dec, input int last, poke, ab, rs);
    start   = 1'b1;
    decrypt = dec;
    tick();
    for (int n = 1; n <= last; n++) begin
      chk(tag, n, obs, exp_at(dec, n));
      start   = (n == poke);
      decrypt = !dec;
      abort   = (n == ab);
      rst_n   = !(n == rs);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
  endtask
  initial begin
    tick();
    tick();
    chk("reset", 0, obs, '0);
    rst_n = 1'b1;
    abort = 1'b1;
    tick();
    chk("idle_abort", 0, obs, '0);
    abort = 1'b0;
    op("enc", 1'b0, 18, -1, -1, -1);
    chk("enc_idle", 19, obs, '0);
    op("dec", 1'b1, 20, -1, -1, -1);
    chk("dec_idle", 21, obs, '0);
    op("busy_start", 1'b0, 18, 6, -1, -1);
    chk("busy_start_idle", 19, obs, '0);
    tick();
    chk("busy_start_stay", 20, obs, '0);
    op("done_start", 1'b0, 18, 18, -1, -1);
    chk("done_start_idle", 19, obs, '0);
    tick();
    chk("done_start_stay", 20, obs, '0);
    op("abort", 1'b0, 8, -1, 8, -1);
    chk("abort_idle", 9, obs, '0);
    tick();
    chk("abort_nodone", 10, obs, '0);
    abort = 1'b1;
    op("abort_restart", 1'b0, 18, -1, -1, -1);
    chk("abort_restart_idle", 19, obs, '0);
    op("dec_abort", 1'b1, 2, -1, 2, -1);
    chk("dec_abort_idle", 3, obs, '0);
    op("reset_final", 1'b0, 17, -1, -1, 17);
    chk("reset_idle", 18, obs, '0);
    tick();
    chk("reset_nodone", 19, obs, '0);
    op("after_reset", 1'b0, 18, -1, -1, -1);
    chk("after_reset_idle", 19, obs, '0);
    start   = 1'b1;
    decrypt = 1'b0;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int n = 1; n <= 18; n++) begin
        chk("b2b", n + 100 * r, obs, exp_at(1'b0, n));
        tick();
      end
      chk("b2b_gap", 19 + 100 * r, obs, '0);
      if (r == 1) start = 1'b0;
      tick();
    end
    chk("b2b_end", 300, obs, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noekeon_round_ctrl.md
Name: noekeon_round_ctrl

Overview:
- Sequencing controller placed directly before the Noekeon data register and the round-function datapath.
- Drives the data register's key-as-data write strobe and its internal write strobe.
- Generates the per-round constants for encryption and decryption, and marks the final output transform.
- Reports busy and done to the external interface; the data block is already loaded externally before start.

Parameters:
- NR, 16, number of full rounds before the final transform.
- RC_INIT, 8'h80, round constant Rc[0].
- RC_POLY, 8'h1B, reduction term of the GF(2^8) step (polynomial 0x11B).

Ports:
- inClk  input  1  clock; all logic on rising edge.
- inReset  input  1  synchronous, active-low reset (0 = reset).
- inStart  input  1  start request; sampled only in IDLE.
- inDecrypt  input  1  mode (1 = decrypt); latched when start is accepted.
- inAbort  input  1  cancel the running operation.
- outBusy  output  1  high in every state except IDLE.
- outDone  output  1  one-cycle pulse when the operation completes.
- outWrKey  output  1  load key into data register (to prepare the working key).
- outKeyPrep  output  1  datapath computes Theta(NullVector, K) this cycle.
- outWrInt  output  1  data register takes the round-function output.
- outFinal  output  1  datapath applies the final transform only (constant add + Theta, no Pi1/Gamma/Pi2).
- outRcIn  output  8  constant XORed before Theta (encrypt), else 0.
- outRcOut  output  8  constant XORed after Theta (decrypt), else 0.
- outRound  output  5  current round index, 0..NR.

Behaviour:
- Reset (inReset=0 at a clock edge): state=IDLE, rc=RC_INIT, round=0, mode=0. All outputs are 0.
- States: IDLE, KEYLD, KEYPREP, ROUND, FINAL, DONE. Encoding is free.
- IDLE:
  - inStart=1: latch mode=inDecrypt.
  - Encrypt: rc=RC_INIT, go to ROUND.
  - Decrypt: rc=Rc[NR] (0xD4 for NR=16), go to KEYLD.
- KEYLD, decrypt only, 1 cycle: outWrKey=1. Next state KEYPREP.
- KEYPREP, 1 cycle: outKeyPrep=1, outWrInt=0. Next state ROUND.
- ROUND, NR cycles:
  - outWrInt=1 every cycle; outRound=round.
  - Round counts 0..NR-1. When round=NR-1, go to FINAL.
- FINAL, 1 cycle: outWrInt=1, outFinal=1, outRound=NR. Next state DONE.
- DONE, 1 cycle: outDone=1, outBusy=1. Next state IDLE; round=0.
- Round constant stepping (rc advances on each ROUND cycle):
  - Encrypt: rc_next = {rc[6:0],1'b0} ^ (rc[7] ? RC_POLY : 0).
  - Decrypt: rc_next = rc[0] ? (((rc ^ RC_POLY) >> 1) | 8'h80) : (rc >> 1).
- Encrypt sequence: Rc[0..NR-1] in the rounds, then Rc[NR] in FINAL.
- Decrypt sequence: Rc[NR..1] in the rounds, then Rc[0]=0x80 in FINAL.
- outRcIn = (ROUND or FINAL) and encrypt ? rc : 0.
- outRcOut = (ROUND or FINAL) and decrypt ? rc : 0.
- Latency from the accepting edge to the outDone pulse: encrypt NR+2 cycles, decrypt NR+4 cycles.
- Boundary conditions:
  - inStart while busy: ignored, with no effect on mode or rc.
  - inStart in the DONE cycle: ignored; the block must return to IDLE first.
  - inAbort=1 in any busy state: next state IDLE, round=0, rc=RC_INIT, no outDone. Abort has priority over all transitions.
  - inAbort in IDLE: no effect. inAbort together with inStart in IDLE: start is accepted and abort is ignored.
  - Reset mid-operation: same as the reset values; no done pulse.
  - Mode changes on inDecrypt after the start is accepted: no effect.
  - outWrKey and outWrInt are never high in the same cycle.

Test Plan:
- Encrypt, NR=16: start with inDecrypt=0.
  - outWrInt high for 17 consecutive cycles.
  - outRcIn = 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A, then D4 with outFinal=1.
  - outDone pulses 18 cycles after the accepting edge.
- Decrypt: start with inDecrypt=1.
  - outWrKey 1 cycle, then outKeyPrep 1 cycle.
  - outRcOut = D4,6A,35,...,36,1B over 16 round cycles, then 80 in FINAL.
  - outRcIn=0 throughout; outDone at cycle 20.
- Start while busy: pulse inStart with inDecrypt=1 at round 5 of an encrypt.
  - Sequence and outRcIn are unchanged.
  - Exactly one outDone pulse.
- Abort at round 7.
  - Next cycle: outBusy=0, all strobes 0, no outDone.
  - A new start then produces outRcIn=80 in the first round.
- Reset low for one edge during FINAL.
  - All outputs are 0 the next cycle; no done pulse.
  - A following encrypt completes normally with latency 18.
- Back-to-back: inStart held high continuously.
  - Second operation begins on the edge after DONE→IDLE (one IDLE cycle between runs).
  - Each run has exactly one outDone pulse.
